mod_instruction_fetch_ctrl: RTL and testbench

Sequencing controller for the word-addressed, combinational instruction ROM. It owns the program counter and drives the ROM address. It buffers fetched words in a small FIFO and hands {pc, instruction} pairs to decode over a valid/ready handshake. It also applies branch/jump redirects and a sticky halt.

---
 rtl/mod_instruction_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_mod_instruction_fetch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mod_instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives a combinational ROM, buffers
// {pc, instruction} pairs in a small FIFO for decode, and handles redirects and halt.
module mod_instruction_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    input  logic        fetch_ready,
    output logic        halted
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, wr_q;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic pop, pop_eff, push, flush;

    assign fetch_valid       = (count_q != '0);
    assign fetch_pc          = mem_pc[rd_q];
    assign fetch_instruction = mem_instr[rd_q];
    assign rom_address       = pc_q;
    assign halted            = (state_q == ST_HALTED);
    assign pop               = fetch_valid & fetch_ready;
    // A flush discards the head, so a same-cycle pop must not advance the read pointer.
    assign pop_eff           = pop & ~flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                if (redirect_valid) pc_d = redirect_target;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_target;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    push = (count_q < DEPTH_C) || pop;
                    if (push) pc_d = pc_q + 32'd1;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_target;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop_eff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (flush) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push)    wr_q <= wr_q + PW'(1);
                if (pop_eff) rd_q <= rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (push) begin
            mem_pc[wr_q]    <= pc_q;
            mem_instr[wr_q] <= rom_instruction;
        end
    end

endmodule

// File: tb/tb_mod_instruction_fetch_ctrl.sv
// Directed bench for mod_instruction_fetch_ctrl: stream, backpressure, redirect,
// halt, simultaneous events, PC wrap and asynchronous reset.
module tb_mod_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_address;
    logic [31:0] rom_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        fetch_ready;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I0 = 32'h0022_1820;
    localparam logic [31:0] I1 = 32'h0485_FFFF;
    localparam logic [31:0] I2 = 32'h0800_0020;

    always #5 clk = ~clk;

    always_comb begin
        case (rom_address)
            32'd0:   rom_instruction = I0;
            32'd1:   rom_instruction = I1;
            32'd2:   rom_instruction = I2;
            default: rom_instruction = 32'd0;
        endcase
    end

    mod_instruction_fetch_ctrl #(
        .RESET_PC (32'd0),
        .DEPTH    (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rom_address       (rom_address),
        .rom_instruction   (rom_instruction),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .halt              (halt),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .fetch_ready       (fetch_ready),
        .halted            (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        chk({tag, "_pc"}, fetch_pc, pc);
        chk({tag, "_instr"}, fetch_instruction, ins);
    endtask

    // Advance one posedge; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        halt            = 1'b0;
        fetch_ready     = 1'b1;
        #12;
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_instr", fetch_instruction, 32'd0);
        chk("rst_addr", rom_address, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Stream
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("edge1_valid", {31'd0, fetch_valid}, 32'd0);
        tick();
        head("s0", 32'd0, I0);
        chk("s0_addr", rom_address, 32'd1);
        tick(); head("s1", 32'd1, I1);
        tick(); head("s2", 32'd2, I2);
        tick(); head("s3", 32'd3, 32'd0);

        // Backpressure
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        head("bp_first", 32'd0, I0);
        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            head("bp_hold", 32'd0, I0);
        end
        chk("bp_addr", rom_address, 32'd2);
        fetch_ready = 1'b1;
        tick(); head("bp_r1", 32'd1, I1);
        tick(); head("bp_r2", 32'd2, I2);
        tick(); head("bp_r3", 32'd3, 32'd0);

        // Redirect while FIFO holds 3,4
        redirect_valid  = 1'b1;
        redirect_target = 32'd2;
        tick();
        redirect_valid = 1'b0;
        chk("rd_bubble", {31'd0, fetch_valid}, 32'd0);
        chk("rd_addr", rom_address, 32'd2);
        tick(); head("rd_t0", 32'd2, I2);
        tick(); head("rd_t1", 32'd3, 32'd0);

        // Halt with buffered entries 0,1 and pc=2
        fetch_ready     = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'd0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        chk("h_pre_addr", rom_address, 32'd2);
        halt = 1'b1;
        tick();
        chk("h_halted", {31'd0, halted}, 32'd1);
        head("h_buf0", 32'd0, I0);
        fetch_ready = 1'b1;
        tick();
        head("h_drain1", 32'd1, I1);
        chk("h_addr1", rom_address, 32'd2);
        tick();
        chk("h_empty", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("h_still_empty", {31'd0, fetch_valid}, 32'd0);
        chk("h_still_halted", {31'd0, halted}, 32'd1);
        chk("h_addr2", rom_address, 32'd2);
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'd0;
        tick();
        redirect_valid = 1'b0;
        chk("h_resume_halted", {31'd0, halted}, 32'd0);
        chk("h_resume_valid", {31'd0, fetch_valid}, 32'd0);
        tick(); head("h_refetch", 32'd0, I0);

        // Halt and redirect together
        halt            = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'd1;
        tick();
        halt           = 1'b0;
        redirect_valid = 1'b0;
        chk("sim_halted", {31'd0, halted}, 32'd0);
        chk("sim_addr", rom_address, 32'd1);
        tick();
        head("sim_head", 32'd1, I1);
        chk("sim_halted2", {31'd0, halted}, 32'd0);

        // PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        head("wrap_hi", 32'hFFFF_FFFF, 32'd0);
        chk("wrap_addr", rom_address, 32'd0);
        tick();
        head("wrap_lo", 32'd0, I0);

        // Asynchronous reset with a full FIFO
        fetch_ready = 1'b0;
        tick(); tick();
        head("ar_full", 32'd0, I0);
        chk("ar_addr_pre", rom_address, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, fetch_valid}, 32'd0);
        chk("ar_addr", rom_address, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
